axi_util_fifo_ft_flow: RTL and testbench

//  Parametrised first-word-fall-through FIFO for AXI channel buffering.

---
 rtl/axi_util_fifo_ft_flow_if.sv | 30 +++
 rtl/axi_util_fifo_ft_flow.sv | 142 ++++++++++++++
 tb/tb_axi_util_fifo_ft_flow.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_util_fifo_ft_flow_if.sv
// Handshake bundle for axi_util_fifo_ft_flow: write side (valid/ready/data)
// and read side (valid/ready/data). slave = FIFO, master = producer/consumer.
interface axi_util_fifo_ft_flow_if #(
    parameter int WIDTH = 32
);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready,
        output rd_valid,
        input  rd_ready,
        output rd_data
    );

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready,
        input  rd_valid,
        output rd_ready,
        input  rd_data
    );
endinterface

// File: rtl/axi_util_fifo_ft_flow.sv
// First-word-fall-through FIFO with registered head, occupancy count,
// almost-full/almost-empty flags and synchronous flush; any depth LEN >= 1.
// Ports: clk, arstn (sync active-low), flush, io (slave: wr_valid/wr_ready/
// wr_data, rd_valid/rd_ready/rd_data), count, almost_full, almost_empty.
// Option AXI_UTIL_FIFO_STATS_EN adds max_count (peak occupancy since clear).
module axi_util_fifo_ft_flow #(
    parameter int LEN        = 4,
    parameter int WIDTH      = 32,
    parameter int AFULL_THR  = LEN - 1,
    parameter int AEMPTY_THR = 1,
    localparam int CW        = $clog2(LEN + 1)
) (
    input  logic                       clk,
    input  logic                       arstn,
    input  logic                       flush,
    axi_util_fifo_ft_flow_if.slave     io,
    output logic [CW-1:0]              count,
    output logic                       almost_full,
    output logic                       almost_empty
`ifdef AXI_UTIL_FIFO_STATS_EN
    ,
    output logic [CW-1:0]              max_count
`endif
);

    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(LEN - 1);
    localparam logic [CW-1:0] AF_C = CW'(AFULL_THR);
    localparam logic [CW-1:0] AE_C = CW'(AEMPTY_THR);

    logic [WIDTH-1:0] mem_q [LEN];

    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic             wr_wrap_q, wr_wrap_d;
    logic             rd_wrap_q, rd_wrap_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic             full, empty, push, pop;
    logic [IW-1:0]    wr_nxt, rd_nxt;

    always_comb begin
        empty = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
        full  = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
        // Explicit wrap keeps non-power-of-2 depths inside the array.
        wr_nxt = (wr_idx_q == LAST) ? '0 : wr_idx_q + 1'b1;
        rd_nxt = (rd_idx_q == LAST) ? '0 : rd_idx_q + 1'b1;
    end

    assign io.wr_ready = !full && arstn;
    assign io.rd_valid = !empty;
    assign io.rd_data  = rd_data_q;

    assign push = io.wr_valid && io.wr_ready;
    assign pop  = io.rd_valid && io.rd_ready;

    always_comb begin
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        wr_wrap_d = wr_wrap_q;
        rd_wrap_d = rd_wrap_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (flush) begin
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            wr_wrap_d = 1'b0;
            rd_wrap_d = 1'b0;
            count_d   = '0;
        end else begin
            if (push) begin
                wr_idx_d = wr_nxt;
                if (wr_idx_q == LAST) wr_wrap_d = !wr_wrap_q;
            end
            if (pop) begin
                rd_idx_d = rd_nxt;
                if (rd_idx_q == LAST) rd_wrap_d = !rd_wrap_q;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // Head register: bypass the incoming word when it becomes the
            // head; otherwise prefetch the next stored entry on a pop.
            if (push && (empty || (pop && count_q == CW'(1)))) begin
                rd_data_d = io.wr_data;
            end else if (pop && count_q > CW'(1)) begin
                rd_data_d = mem_q[rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            wr_wrap_q <= 1'b0;
            rd_wrap_q <= 1'b0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            wr_wrap_q <= wr_wrap_d;
            rd_wrap_q <= rd_wrap_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is never cleared; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_idx_q] <= io.wr_data;
    end

    assign count        = count_q;
    assign almost_full  = count_q >= AF_C;
    assign almost_empty = count_q <= AE_C;

`ifdef AXI_UTIL_FIFO_STATS_EN
    logic [CW-1:0] max_count_q, max_count_d;

    always_comb begin
        max_count_d = max_count_q;
        if (flush) begin
            max_count_d = '0;
        end else if (count_d > max_count_q) begin
            max_count_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) max_count_q <= '0;
        else        max_count_q <= max_count_d;
    end

    assign max_count = max_count_q;
`endif

endmodule

// File: tb/tb_axi_util_fifo_ft_flow.sv
// Directed testbench for axi_util_fifo_ft_flow: LEN=4 instance for fill,
// drain, bypass, flush, full-pop and reset; LEN=3 instance for wrap order.
module tb_axi_util_fifo_ft_flow;

    logic clk = 1'b0;
    logic arstn;
    logic flush4, flush3;
    logic [2:0] count4, count3;
    logic af4, ae4, af3, ae3;
`ifdef AXI_UTIL_FIFO_STATS_EN
    logic [2:0] max4;
    logic [1:0] max3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_util_fifo_ft_flow_if #(.WIDTH(32)) bus4 ();
    axi_util_fifo_ft_flow_if #(.WIDTH(32)) bus3 ();

    axi_util_fifo_ft_flow #(.LEN(4), .WIDTH(32)) dut4 (
        .clk          (clk),
        .arstn        (arstn),
        .flush        (flush4),
        .io           (bus4.slave),
        .count        (count4),
        .almost_full  (af4),
        .almost_empty (ae4)
`ifdef AXI_UTIL_FIFO_STATS_EN
        ,
        .max_count    (max4)
`endif
    );

    axi_util_fifo_ft_flow #(.LEN(3), .WIDTH(32)) dut3 (
        .clk          (clk),
        .arstn        (arstn),
        .flush        (flush3),
        .io           (bus3.slave),
        .count        (count3[1:0]),
        .almost_full  (af3),
        .almost_empty (ae3)
`ifdef AXI_UTIL_FIFO_STATS_EN
        ,
        .max_count    (max3)
`endif
    );
    assign count3[2] = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input logic [31:0] d);
        bus4.wr_valid = 1'b1;
        bus4.wr_data  = d;
        tick();
        bus4.wr_valid = 1'b0;
    endtask

    bit pv [12] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0, 1};
    bit rv [12] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1};
    logic [31:0] q [$];

    initial begin
        arstn = 1'b0;
        flush4 = 1'b0;
        flush3 = 1'b0;
        bus4.wr_valid = 1'b0;
        bus4.wr_data  = '0;
        bus4.rd_ready = 1'b0;
        bus3.wr_valid = 1'b0;
        bus3.wr_data  = '0;
        bus3.rd_ready = 1'b0;
        tick();
        tick();
        chk("rst_count", count4, 0);
        chk("rst_rd_valid", bus4.rd_valid, 0);
        chk("rst_rd_data", bus4.rd_data, 0);
        chk("rst_aempty", ae4, 1);
        chk("rst_afull", af4, 0);
        chk("rst_wr_ready", bus4.wr_ready, 0);
        arstn = 1'b1;
        tick();
        chk("run_wr_ready", bus4.wr_ready, 1);

        // Fill A..D with no reads.
        push4(32'hA);
        chk("f1_count", count4, 1);
        chk("f1_rd_valid", bus4.rd_valid, 1);
        chk("f1_rd_data", bus4.rd_data, 32'hA);
        chk("f1_aempty", ae4, 1);
        push4(32'hB);
        chk("f2_count", count4, 2);
        chk("f2_aempty", ae4, 0);
        chk("f2_afull", af4, 0);
        push4(32'hC);
        chk("f3_count", count4, 3);
        chk("f3_afull", af4, 1);
        push4(32'hD);
        chk("f4_count", count4, 4);
        chk("f4_wr_ready", bus4.wr_ready, 0);
        chk("f4_rd_data", bus4.rd_data, 32'hA);
`ifdef AXI_UTIL_FIFO_STATS_EN
        chk("f4_max", max4, 4);
`endif

        // Drain back-to-back.
        bus4.rd_ready = 1'b1;
        tick();
        chk("d1_rd_data", bus4.rd_data, 32'hB);
        chk("d1_count", count4, 3);
        chk("d1_wr_ready", bus4.wr_ready, 1);
        tick();
        chk("d2_rd_data", bus4.rd_data, 32'hC);
        tick();
        chk("d3_rd_data", bus4.rd_data, 32'hD);
        chk("d3_count", count4, 1);
        tick();
        chk("d4_count", count4, 0);
        chk("d4_rd_valid", bus4.rd_valid, 0);
        tick();
        chk("d5_count", count4, 0);
        bus4.rd_ready = 1'b0;

        // Push into empty, then push+pop at count 1.
        push4(32'h55);
        chk("e_rd_valid", bus4.rd_valid, 1);
        chk("e_rd_data", bus4.rd_data, 32'h55);
        bus4.rd_ready = 1'b1;
        push4(32'h66);
        bus4.rd_ready = 1'b0;
        chk("bp_count", count4, 1);
        chk("bp_rd_data", bus4.rd_data, 32'h66);
        push4(32'h77);
        push4(32'h88);
        chk("pre_flush_count", count4, 3);
        chk("pre_flush_head", bus4.rd_data, 32'h66);

        // Flush wins over a simultaneous write.
        flush4 = 1'b1;
        bus4.wr_valid = 1'b1;
        bus4.wr_data  = 32'h99;
        tick();
        flush4 = 1'b0;
        bus4.wr_valid = 1'b0;
        chk("fl_count", count4, 0);
        chk("fl_rd_valid", bus4.rd_valid, 0);
`ifdef AXI_UTIL_FIFO_STATS_EN
        chk("fl_max", max4, 0);
`endif
        tick();
        chk("fl_drop_count", count4, 0);
        push4(32'hAA);
        chk("pf_rd_data", bus4.rd_data, 32'hAA);
        push4(32'hBB);
        push4(32'hCC);
        push4(32'hDD);
        chk("pf_full", bus4.wr_ready, 0);

        // Pop while full with a waiting write: write refused this cycle.
        bus4.wr_valid = 1'b1;
        bus4.wr_data  = 32'hEE;
        bus4.rd_ready = 1'b1;
        tick();
        bus4.wr_valid = 1'b0;
        bus4.rd_ready = 1'b0;
        chk("fp_count", count4, 3);
        chk("fp_rd_data", bus4.rd_data, 32'hBB);
        chk("fp_wr_ready", bus4.wr_ready, 1);

        // Reset mid-fill.
        bus4.wr_valid = 1'b1;
        bus4.wr_data  = 32'hFF;
        arstn = 1'b0;
        tick();
        bus4.wr_valid = 1'b0;
        chk("mr_count", count4, 0);
        chk("mr_rd_valid", bus4.rd_valid, 0);
        chk("mr_rd_data", bus4.rd_data, 0);
        chk("mr_aempty", ae4, 1);
        chk("mr_afull", af4, 0);
        chk("mr_wr_ready", bus4.wr_ready, 0);
`ifdef AXI_UTIL_FIFO_STATS_EN
        chk("mr_max", max4, 0);
`endif
        arstn = 1'b1;
        tick();

        // LEN=3 interleaved traffic across the index wrap.
        for (int i = 0; i < 12; i++) begin
            logic do_push, do_pop;
            logic [31:0] d;
            d = 32'h30 + 32'(i);
            bus3.wr_valid = pv[i];
            bus3.wr_data  = d;
            bus3.rd_ready = rv[i];
            chk("l3_wr_ready", bus3.wr_ready, {31'd0, q.size() < 3});
            do_push = pv[i] && (q.size() < 3);
            do_pop  = rv[i] && (q.size() > 0);
            tick();
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
            chk("l3_count", count3, q.size());
            chk("l3_rd_valid", bus3.rd_valid, {31'd0, q.size() != 0});
            if (q.size() > 0) chk("l3_rd_data", bus3.rd_data, q[0]);
        end
        bus3.wr_valid = 1'b0;
        bus3.rd_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
